// File: rtl/reg32_nibble_reader.sv
// Captures a 32-bit word on load and presents it as eight 4-bit nibbles
// under a valid/ready handshake, pulsing done for one cycle after the last nibble.
module reg32_nibble_reader #(
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic [31:0] d_i,
   input  logic        load_i,
   input  logic        nib_ready_i,
   output logic [3:0]  nib_o,
   output logic        nib_valid_o,
   output logic        last_o,
   output logic        busy_o,
   output logic        done_o
);

   // state | meaning
   // IDLE  | waiting for load; outputs quiet
   // SEND  | presenting nibble idx_q of the shadow word
   // DONE  | single-cycle done pulse, then back to IDLE
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic [31:0] shadow_q, shadow_d;
   logic [2:0]  sel;
   logic [4:0]  lsb;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= IDLE;
         idx_q    <= 3'd0;
         shadow_q <= 32'h0000_0000;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      shadow_d = shadow_q;
      case (state_q)
         IDLE: begin
            if (load_i) begin
               shadow_d = d_i;
               idx_d    = 3'd0;
               state_d  = SEND;
            end
         end
         SEND: begin
            // idx stops at 7; the final transfer exits instead of wrapping
            if (nib_ready_i) begin
               if (idx_q == 3'd7) begin
                  state_d = DONE;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // MSB-first order walks nibble slots 7..0, i.e. the bitwise inverse of idx
   assign sel = MSB_FIRST ? ~idx_q : idx_q;
   assign lsb = {sel, 2'b00};

   always_comb begin
      nib_o       = 4'h0;
      nib_valid_o = 1'b0;
      last_o      = 1'b0;
      busy_o      = 1'b0;
      done_o      = 1'b0;
      case (state_q)
         SEND: begin
            nib_o       = shadow_q[lsb +: 4];
            nib_valid_o = 1'b1;
            last_o      = (idx_q == 3'd7);
            busy_o      = 1'b1;
         end
         DONE: begin
            busy_o = 1'b1;
            done_o = 1'b1;
         end
         default: begin
            nib_o = 4'h0;
         end
      endcase
   end

endmodule

// File: tb/tb_reg32_nibble_reader.sv
// Self-checking bench for reg32_nibble_reader: one instance per nibble order,
// expected nibbles queued at load time and popped on each transfer.
module tb_reg32_nibble_reader;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        load = 1'b0;
   logic        nib_ready = 1'b0;
   logic [31:0] d = 32'h0;

   logic [3:0] nib0, nib1;
   logic       v0, v1, l0, l1, b0, b1, dn0, dn1;

   int checks = 0;
   int passed = 0;

   logic [3:0] q0[$];
   logic [3:0] q1[$];

   always #5 clk = ~clk;

   reg32_nibble_reader #(.MSB_FIRST(1'b0)) u0 (
      .clk_i(clk), .reset_i(reset), .d_i(d), .load_i(load), .nib_ready_i(nib_ready),
      .nib_o(nib0), .nib_valid_o(v0), .last_o(l0), .busy_o(b0), .done_o(dn0)
   );

   reg32_nibble_reader #(.MSB_FIRST(1'b1)) u1 (
      .clk_i(clk), .reset_i(reset), .d_i(d), .load_i(load), .nib_ready_i(nib_ready),
      .nib_o(nib1), .nib_valid_o(v1), .last_o(l1), .busy_o(b1), .done_o(dn1)
   );

   function automatic logic [3:0] exp_nib(input logic [31:0] w, input bit msb, input int i);
      logic [31:0] s;
      s = msb ? (w >> (28 - 4 * i)) : (w >> (4 * i));
      return s[3:0];
   endfunction

   // Called on a falling edge: pulses load for one edge and queues the expected nibbles.
   task automatic load_word(input logic [31:0] word);
      d    = word;
      load = 1'b1;
      for (int i = 0; i < 8; i++) begin
         q0.push_back(exp_nib(word, 1'b0, i));
         q1.push_back(exp_nib(word, 1'b1, i));
      end
      @(negedge clk);
      load = 1'b0;
      d    = ~word;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      load = 1'b1;
      nib_ready = 1'b1;
      d = 32'h0F0F_0F0F;
      #1;
      checks++; if ({nib0, v0, l0, b0, dn0} !== 8'h00) $display("FAIL reset_out0: got %b want 00000000", {nib0, v0, l0, b0, dn0}); else passed++;
      checks++; if ({nib1, v1, l1, b1, dn1} !== 8'h00) $display("FAIL reset_out1: got %b want 00000000", {nib1, v1, l1, b1, dn1}); else passed++;
      repeat (2) @(negedge clk);
      checks++; if ({b0, v0, b1, v1} !== 4'b0000) $display("FAIL reset_load_ignored: got %b want 0000", {b0, v0, b1, v1}); else passed++;
      reset = 1'b0;
      @(negedge clk);
      load = 1'b0;
      checks++; if ({b0, v0} !== 2'b11) $display("FAIL first_capture: busy/valid got %b want 11", {b0, v0}); else passed++;
      checks++; if (nib0 !== 4'hF) $display("FAIL first_capture_nib0: got %h want f", nib0); else passed++;
      checks++; if (nib1 !== 4'h0) $display("FAIL first_capture_nib1: got %h want 0", nib1); else passed++;
      reset = 1'b1;
      #1;
      checks++; if ({nib0, v0, b0} !== 6'h00) $display("FAIL reset_abort: got %b want 000000", {nib0, v0, b0}); else passed++;
      reset = 1'b0;
      nib_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++; if ({v0, b0, dn0, nib0} !== 7'h00) $display("FAIL idle_ready_no_effect: got %b want 0000000", {v0, b0, dn0, nib0}); else passed++;
   endtask

   task automatic test_back_to_back();
      nib_ready = 1'b1;
      load_word(32'hAFAF_AFAF);
      for (int c = 0; c < 8; c++) begin
         checks++; if ({v0, b0} !== 2'b11) $display("FAIL b2b_valid c=%0d: got %b want 11", c, {v0, b0}); else passed++;
         checks++; if (nib0 !== q0[0]) $display("FAIL b2b_nib0 c=%0d: got %h want %h", c, nib0, q0[0]); else passed++;
         checks++; if (nib1 !== q1[0]) $display("FAIL b2b_nib1 c=%0d: got %h want %h", c, nib1, q1[0]); else passed++;
         checks++; if (l0 !== (c == 7)) $display("FAIL b2b_last c=%0d: got %b want %b", c, l0, (c == 7)); else passed++;
         void'(q0.pop_front());
         void'(q1.pop_front());
         @(negedge clk);
      end
      checks++; if ({dn0, b0, v0, l0, nib0} !== 8'b1100_0000) $display("FAIL b2b_done: got %b want 11000000", {dn0, b0, v0, l0, nib0}); else passed++;
      checks++; if (dn1 !== 1'b1) $display("FAIL b2b_done1: got %b want 1", dn1); else passed++;
      @(negedge clk);
      checks++; if ({dn0, b0, v0} !== 3'b000) $display("FAIL b2b_idle: got %b want 000", {dn0, b0, v0}); else passed++;
   endtask

   task automatic test_order();
      nib_ready = 1'b1;
      load_word(32'h1234_5678);
      for (int c = 0; c < 8; c++) begin
         checks++; if (nib0 !== q0[0]) $display("FAIL order_lsb c=%0d: got %h want %h", c, nib0, q0[0]); else passed++;
         checks++; if (nib1 !== q1[0]) $display("FAIL order_msb c=%0d: got %h want %h", c, nib1, q1[0]); else passed++;
         checks++; if (l1 !== (c == 7)) $display("FAIL order_last1 c=%0d: got %b want %b", c, l1, (c == 7)); else passed++;
         void'(q0.pop_front());
         void'(q1.pop_front());
         @(negedge clk);
      end
      checks++; if ({dn0, dn1} !== 2'b11) $display("FAIL order_done: got %b want 11", {dn0, dn1}); else passed++;
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      int xfer;
      int stall;
      xfer = 0;
      stall = 0;
      nib_ready = 1'b1;
      load_word(32'hFFFF_FFFF);
      for (int cyc = 0; cyc < 20 && xfer < 8; cyc++) begin
         if (xfer == 2 && stall < 3) begin
            nib_ready = 1'b0;
            stall++;
         end else begin
            nib_ready = 1'b1;
         end
         checks++; if (v0 !== 1'b1) $display("FAIL bp_valid cyc=%0d: got %b want 1", cyc, v0); else passed++;
         checks++; if (nib0 !== q0[0]) $display("FAIL bp_nib cyc=%0d: got %h want %h", cyc, nib0, q0[0]); else passed++;
         checks++; if (l0 !== (xfer == 7)) $display("FAIL bp_last cyc=%0d: got %b want %b", cyc, l0, (xfer == 7)); else passed++;
         checks++; if (dn0 !== 1'b0) $display("FAIL bp_early_done cyc=%0d: got %b want 0", cyc, dn0); else passed++;
         if (nib_ready) begin
            void'(q0.pop_front());
            void'(q1.pop_front());
            xfer++;
         end
         @(negedge clk);
      end
      nib_ready = 1'b1;
      checks++; if ({dn0, v0} !== 2'b10) $display("FAIL bp_done: got %b want 10", {dn0, v0}); else passed++;
      @(negedge clk);
      checks++; if (b0 !== 1'b0) $display("FAIL bp_idle: got %b want 0", b0); else passed++;
   endtask

   task automatic test_ignored_load();
      nib_ready = 1'b1;
      load_word(32'h0000_000F);
      for (int c = 0; c < 8; c++) begin
         if (c == 2) begin
            load = 1'b1;
            d = 32'hFFFF_FFFF;
         end else begin
            load = 1'b0;
         end
         checks++; if (nib0 !== q0[0]) $display("FAIL ign_nib0 c=%0d: got %h want %h", c, nib0, q0[0]); else passed++;
         checks++; if (nib1 !== q1[0]) $display("FAIL ign_nib1 c=%0d: got %h want %h", c, nib1, q1[0]); else passed++;
         void'(q0.pop_front());
         void'(q1.pop_front());
         @(negedge clk);
      end
      load = 1'b0;
      checks++; if (dn0 !== 1'b1) $display("FAIL ign_done: got %b want 1", dn0); else passed++;
      repeat (2) begin
         @(negedge clk);
         checks++; if ({b0, v0, dn0} !== 3'b000) $display("FAIL ign_no_second_word: got %b want 000", {b0, v0, dn0}); else passed++;
      end
   endtask

   task automatic test_async_reset();
      nib_ready = 1'b1;
      load_word(32'hDEAD_BEEF);
      for (int c = 0; c < 4; c++) begin
         checks++; if (nib0 !== q0[0]) $display("FAIL ar_pre_nib c=%0d: got %h want %h", c, nib0, q0[0]); else passed++;
         void'(q0.pop_front());
         void'(q1.pop_front());
         @(negedge clk);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++; if ({nib0, v0, l0, b0, dn0} !== 8'h00) $display("FAIL ar_immediate0: got %b want 00000000", {nib0, v0, l0, b0, dn0}); else passed++;
      checks++; if ({nib1, v1, l1, b1, dn1} !== 8'h00) $display("FAIL ar_immediate1: got %b want 00000000", {nib1, v1, l1, b1, dn1}); else passed++;
      #1;
      reset = 1'b0;
      q0.delete();
      q1.delete();
      repeat (2) begin
         @(negedge clk);
         checks++; if ({dn0, b0, v0} !== 3'b000) $display("FAIL ar_no_done: got %b want 000", {dn0, b0, v0}); else passed++;
      end
      load_word(32'h8765_4321);
      for (int c = 0; c < 8; c++) begin
         checks++; if (nib0 !== q0[0]) $display("FAIL ar_new_nib c=%0d: got %h want %h", c, nib0, q0[0]); else passed++;
         checks++; if (l0 !== (c == 7)) $display("FAIL ar_new_last c=%0d: got %b want %b", c, l0, (c == 7)); else passed++;
         void'(q0.pop_front());
         void'(q1.pop_front());
         @(negedge clk);
      end
      checks++; if (dn0 !== 1'b1) $display("FAIL ar_new_done: got %b want 1", dn0); else passed++;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_order();
      test_backpressure();
      test_ignored_load();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
